// File: rtl/canny_hysteresis_link_if.sv
// ---------------------------------------------------------------------------
// canny_hysteresis_link_if
//
// Groups the stream, threshold and status signals of the hysteresis
// edge-linking stage. The clock and reset stay outside the bundle.
//
//   start_sync  frame-active flag from NMS; a rising edge arms a frame
//   data_en     in_data is valid this cycle
//   in_data     16-bit magnitude word, only the low MAG_WIDTH bits are used
//   th_high     strong threshold, captured when a frame is armed
//   th_low      weak threshold, captured when a frame is armed
//   edge_out    8'd255 for an edge pixel, 8'd0 otherwise
//   edge_en     edge_out carries a pixel this cycle
//   frame_done  one-cycle pulse after the last output pixel of a frame
//   busy        a frame is being accepted or flushed
//
// master: the producer/consumer around the block (drives the stream).
// slave : the edge-linking block itself.
// ---------------------------------------------------------------------------
interface canny_hysteresis_link_if;
    logic        start_sync;
    logic        data_en;
    logic [15:0] in_data;
    logic [12:0] th_high;
    logic [12:0] th_low;
    logic [7:0]  edge_out;
    logic        edge_en;
    logic        frame_done;
    logic        busy;

    modport master (
        output start_sync, data_en, in_data, th_high, th_low,
        input  edge_out, edge_en, frame_done, busy
    );

    modport slave (
        input  start_sync, data_en, in_data, th_high, th_low,
        output edge_out, edge_en, frame_done, busy
    );
endinterface

// File: rtl/canny_hysteresis_link.sv
// ---------------------------------------------------------------------------
// canny_hysteresis_link
//
// Double-threshold and hysteresis edge-linking stage of the Canny pipeline.
// Every incoming magnitude is classified as strong (2), weak (1) or none (0).
// Classes of the two previous rows are kept in line buffers and a 3x3 class
// window slides over the stream. A pixel is an edge when it is strong, or
// when it is weak and touches at least one strong neighbour (single pass).
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   canny_hysteresis_link_if.slave (stream in, edge image out)
//
// Parameters:
//   IMG_WIDTH   pixels per row
//   IMG_HEIGHT  rows per frame
//   MAG_WIDTH   valid magnitude bits of in_data (at most 13)
//
// Pipeline: the cycle a pixel is accepted its class enters the window and
// the line buffers; one cycle later the edge decision is registered onto
// edge_out/edge_en. The window centre therefore lags the input by
// IMG_WIDTH+1 pixels, which FLUSH makes up with zero-class pixels.
// ---------------------------------------------------------------------------
module canny_hysteresis_link #(
    parameter int IMG_WIDTH  = 510,
    parameter int IMG_HEIGHT = 634,
    parameter int MAG_WIDTH  = 13
) (
    input logic                    clk,
    input logic                    rst,
    canny_hysteresis_link_if.slave bus
);

    localparam int COL_W         = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W         = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PIX_TOTAL     = IMG_WIDTH * IMG_HEIGHT;
    // First pixel count that no longer produces a flush pixel.
    localparam int FLUSH_PIX_END = PIX_TOTAL + IMG_WIDTH + 1;
    // Last FLUSH cycle: two extra cycles let the final pixel leave the
    // window stage and the decision register before frame_done.
    localparam int FLUSH_LAST    = FLUSH_PIX_END + 1;
    localparam int CNT_W         = $clog2(FLUSH_LAST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic             startPrev_q;
    logic [12:0]      thHigh_q;
    logic [12:0]      thLow_q;
    logic [CNT_W-1:0] pixCnt_q;
    logic [COL_W-1:0] inCol_q;
    logic [1:0]       rowValid_q;
    logic [COL_W-1:0] outCol_q;
    logic [ROW_W-1:0] outRow_q;

    // Class window: first index is the row (0 = oldest), second the column
    // (0 = oldest, 2 = newest).
    logic [2:0][2:0][1:0] win_q;
    logic                 candValid_q;
    logic                 maskTop_q;
    logic                 maskBot_q;
    logic                 maskLeft_q;
    logic                 maskRight_q;

    logic [7:0] edgeOut_q;
    logic       edgeEn_q;

    logic [1:0] lb1_q [IMG_WIDTH];
    logic [1:0] lb2_q [IMG_WIDTH];

    logic        startRise;
    logic [12:0] mag;
    logic [1:0]  magClass;
    logic        arm;
    logic        pixValid;
    logic [1:0]  pixClass;
    logic        cntInc;
    logic        busyComb;
    logic        frameDoneComb;
    logic        strongNb;
    logic        isEdge;
    logic        unusedInBits;

    assign startRise    = bus.start_sync & ~startPrev_q;
    assign unusedInBits = ^bus.in_data[15:MAG_WIDTH];

    // Classification against the thresholds captured at frame arm. Testing
    // strong first means an inverted threshold pair leaves no weak band.
    always_comb begin
        mag = 13'(bus.in_data[MAG_WIDTH-1:0]);
        magClass = 2'd0;
        if (mag >= thHigh_q) begin
            magClass = 2'd2;
        end else if (mag >= thLow_q) begin
            magClass = 2'd1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle strobes. A pixel enters the window either
    // from the stream in RUN or as a zero-class filler in FLUSH; FLUSH keeps
    // counting through its drain cycles so one counter times the whole tail.
    always_comb begin
        state_d       = state_q;
        arm           = 1'b0;
        pixValid      = 1'b0;
        pixClass      = 2'd0;
        cntInc        = 1'b0;
        busyComb      = 1'b0;
        frameDoneComb = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startRise) begin
                    arm     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busyComb = 1'b1;
                if (bus.data_en) begin
                    pixValid = 1'b1;
                    pixClass = magClass;
                    cntInc   = 1'b1;
                    if (pixCnt_q == CNT_W'(PIX_TOTAL - 1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                busyComb = 1'b1;
                cntInc   = 1'b1;
                if (pixCnt_q < CNT_W'(FLUSH_PIX_END)) begin
                    pixValid = 1'b1;
                end
                if (pixCnt_q == CNT_W'(FLUSH_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frameDoneComb = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Class line buffers: lb1 holds the previous row, lb2 the one before.
    // Contents need no reset because rows that were never written are
    // masked by rowValid_q and by the output position counters.
    always_ff @(posedge clk) begin
        if (pixValid) begin
            lb1_q[inCol_q] <= pixClass;
            lb2_q[inCol_q] <= lb1_q[inCol_q];
        end
    end

    // Window stage. Each accepted pixel shifts a new column into the window
    // (row r-2, row r-1, row r at the input column). Once IMG_WIDTH+1 pixels
    // have arrived the window middle is a real output pixel, whose position
    // is tracked separately so that image borders are masked by position
    // rather than by whatever wrapped into the window from the adjacent row.
    always_ff @(posedge clk) begin
        if (rst) begin
            startPrev_q <= 1'b0;
            thHigh_q    <= '0;
            thLow_q     <= '0;
            pixCnt_q    <= '0;
            inCol_q     <= '0;
            rowValid_q  <= '0;
            outCol_q    <= '0;
            outRow_q    <= '0;
            win_q       <= '0;
            candValid_q <= 1'b0;
            maskTop_q   <= 1'b0;
            maskBot_q   <= 1'b0;
            maskLeft_q  <= 1'b0;
            maskRight_q <= 1'b0;
        end else begin
            startPrev_q <= bus.start_sync;
            candValid_q <= 1'b0;
            if (arm) begin
                thHigh_q   <= bus.th_high;
                thLow_q    <= bus.th_low;
                pixCnt_q   <= '0;
                inCol_q    <= '0;
                rowValid_q <= '0;
                outCol_q   <= '0;
                outRow_q   <= '0;
            end
            if (cntInc) begin
                pixCnt_q <= pixCnt_q + 1'b1;
            end
            if (pixValid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= rowValid_q[1] ? lb2_q[inCol_q] : 2'd0;
                win_q[1][2] <= rowValid_q[0] ? lb1_q[inCol_q] : 2'd0;
                win_q[2][2] <= pixClass;

                if (inCol_q == COL_W'(IMG_WIDTH - 1)) begin
                    inCol_q    <= '0;
                    rowValid_q <= {rowValid_q[0], 1'b1};
                end else begin
                    inCol_q <= inCol_q + 1'b1;
                end

                if (pixCnt_q >= CNT_W'(IMG_WIDTH + 1)) begin
                    candValid_q <= 1'b1;
                    maskTop_q   <= (outRow_q == '0);
                    maskBot_q   <= (outRow_q == ROW_W'(IMG_HEIGHT - 1));
                    maskLeft_q  <= (outCol_q == '0);
                    maskRight_q <= (outCol_q == COL_W'(IMG_WIDTH - 1));
                    if (outCol_q == COL_W'(IMG_WIDTH - 1)) begin
                        outCol_q <= '0;
                        outRow_q <= outRow_q + 1'b1;
                    end else begin
                        outCol_q <= outCol_q + 1'b1;
                    end
                end
            end
        end
    end

    // Strong-neighbour search over the eight window cells that lie inside
    // the image.
    always_comb begin
        strongNb = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1)
                    && !(r == 0 && maskTop_q) && !(r == 2 && maskBot_q)
                    && !(c == 0 && maskLeft_q) && !(c == 2 && maskRight_q)
                    && (win_q[r][c] == 2'd2)) begin
                    strongNb = 1'b1;
                end
            end
        end
        isEdge = (win_q[1][1] == 2'd2) || ((win_q[1][1] == 2'd1) && strongNb);
    end

    // Decision register; edge_out is forced to 0 on cycles without output.
    always_ff @(posedge clk) begin
        if (rst) begin
            edgeOut_q <= 8'd0;
            edgeEn_q  <= 1'b0;
        end else begin
            edgeEn_q  <= candValid_q;
            edgeOut_q <= (candValid_q && isEdge) ? 8'd255 : 8'd0;
        end
    end

    assign bus.edge_out   = edgeOut_q;
    assign bus.edge_en    = edgeEn_q;
    assign bus.frame_done = frameDoneComb;
    assign bus.busy       = busyComb;

endmodule
